// File: rtl/serial_s_pkg.sv
// Shared types and constants for the serial_s fixed-message UART transmitter.
// Optional even parity is enabled by defining SERIAL_S_PARITY_EN.
package serial_s_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam int unsigned MSG_LEN    = 7;
    localparam int unsigned DEF_CLK_HZ = 50_000_000;
    localparam int unsigned DEF_BAUD   = 115_200;

    // "Hello\r\n"
    localparam logic [7:0] MSG_BYTES [MSG_LEN] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A
    };

    function automatic logic [7:0] msg_byte(input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (idx == 3'(i)) b = MSG_BYTES[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/serial_s_tx_byte.sv
// Single-byte UART serialiser: baud counter plus START/DATA/[PARITY]/STOP sequencing.
// Defining SERIAL_S_PARITY_EN inserts an even-parity bit between DATA and STOP.
module serial_s_tx_byte
    import serial_s_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam logic [15:0] LastCnt = 16'(DIV - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
`ifdef SERIAL_S_PARITY_EN
    logic        par_q, par_d;
`endif

    logic last_cnt;
    assign last_cnt = (cnt_q == LastCnt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done    = 1'b0;
`ifdef SERIAL_S_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (load) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    shift_d = data;
                    tx_d    = 1'b0;
`ifdef SERIAL_S_PARITY_EN
                    par_d   = ^data;
`endif
                end
            end
            StStart: begin
                cnt_d = cnt_q + 16'd1;
                if (last_cnt) begin
                    state_d = StData;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                cnt_d = cnt_q + 16'd1;
                if (last_cnt) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef SERIAL_S_PARITY_EN
                        state_d = StParity;
                        tx_d    = par_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
`ifdef SERIAL_S_PARITY_EN
            StParity: begin
                cnt_d = cnt_q + 16'd1;
                if (last_cnt) begin
                    state_d = StStop;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                cnt_d = cnt_q + 16'd1;
                if (last_cnt) begin
                    done  = 1'b1;
                    cnt_d = '0;
                    // A load on the stop-completion cycle chains the next frame with no idle gap.
                    if (load) begin
                        state_d = StStart;
                        shift_d = data;
                        tx_d    = 1'b0;
`ifdef SERIAL_S_PARITY_EN
                        par_d   = ^data;
`endif
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef SERIAL_S_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef SERIAL_S_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);
    assign tx   = tx_q;

endmodule

// File: rtl/serial_s.sv
// Fixed-message UART transmitter: a rising edge on start_send sends "Hello\r\n" on TDX.
// Define SERIAL_S_PARITY_EN for 8E1 framing instead of 8N1.
module serial_s
    import serial_s_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned BAUD   = DEF_BAUD,
    parameter int unsigned DIV    = CLK_HZ / BAUD
) (
    input  logic m_clock,
    input  logic p_reset,
    input  logic start_send,
    output logic TDX
);

    localparam logic [2:0] LastIdx = 3'(MSG_LEN - 1);

    logic       start_send_q;
    logic [2:0] byte_idx_q, byte_idx_d;
    logic       start_req;
    logic       load;
    logic [7:0] load_data;
    logic       busy;
    logic       done;

    assign start_req = start_send & ~start_send_q;

    // Requests while a message is in flight are dropped, not queued.
    always_comb begin
        byte_idx_d = byte_idx_q;
        load       = 1'b0;
        load_data  = msg_byte(3'd0);
        if (start_req && !busy) begin
            load       = 1'b1;
            byte_idx_d = 3'd0;
            load_data  = msg_byte(3'd0);
        end else if (done && (byte_idx_q < LastIdx)) begin
            load       = 1'b1;
            byte_idx_d = byte_idx_q + 3'd1;
            load_data  = msg_byte(byte_idx_q + 3'd1);
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            start_send_q <= 1'b0;
            byte_idx_q   <= '0;
        end else begin
            start_send_q <= start_send;
            byte_idx_q   <= byte_idx_d;
        end
    end

    serial_s_tx_byte #(
        .DIV (DIV)
    ) u_tx_byte (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .load    (load),
        .data    (load_data),
        .busy    (busy),
        .done    (done),
        .tx      (TDX)
    );

endmodule

// File: tb/tb_serial_s.sv
// Directed self-checking bench for serial_s, run with a short bit period (DIV = 16).
module tb_serial_s;

    localparam int unsigned DIV = 16;

    logic m_clock = 1'b0;
    logic p_reset;
    logic start_send;
    logic TDX;

    int checks = 0;
    int fails  = 0;
    int unsigned cyc = 0;
    int unsigned last_rise = 0;
    int unsigned t0 = 0;
    logic prev_tdx = 1'b1;

    logic [7:0] msg [7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

    serial_s #(
        .CLK_HZ (1600),
        .BAUD   (100)
    ) dut (
        .m_clock    (m_clock),
        .p_reset    (p_reset),
        .start_send (start_send),
        .TDX        (TDX)
    );

    always #5 m_clock = ~m_clock;

    always @(posedge m_clock) begin
        cyc = cyc + 1;
        #1;
        if (TDX === 1'b1 && prev_tdx === 1'b0) last_rise = cyc;
        prev_tdx = TDX;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits up to 'bound' cycles for a start bit, then samples each bit mid-period.
    task automatic recv_byte(output logic [7:0] b, output bit ok, input int bound);
        int n;
        n  = 0;
        ok = 1'b0;
        b  = 8'h00;
        @(negedge m_clock);
        while (TDX !== 1'b0 && n < bound) begin
            @(negedge m_clock);
            n++;
        end
        if (TDX !== 1'b0) return;
        repeat (DIV / 2) @(negedge m_clock);
        if (TDX !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge m_clock);
            b[i] = TDX;
        end
        repeat (DIV) @(negedge m_clock);
        ok = (TDX === 1'b1);
    endtask

    task automatic pulse();
        @(negedge m_clock);
        start_send = 1'b1;
        @(negedge m_clock);
        start_send = 1'b0;
    endtask

    initial begin
        logic [9:0] frame0;
        logic [7:0] rx;
        bit         ok;
        int         errs;
        int         good;

        frame0     = 10'b10_1001_0000;
        p_reset    = 1'b1;
        start_send = 1'b0;
        #3 p_reset = 1'b0;

        // Reset held with start_send toggling
        for (int i = 0; i < 5; i++) begin
            @(negedge m_clock);
            start_send = ~start_send;
            check("reset_hold_tdx", {31'd0, TDX}, 32'd1);
        end
        @(negedge m_clock);
        start_send = 1'b0;
        @(negedge m_clock);
        p_reset = 1'b1;
        recv_byte(rx, ok, 4 * DIV);
        check("no_frame_after_reset", {31'd0, ok}, 32'd0);

        // Single pulse: latency and exact first-frame waveform
        @(negedge m_clock);
        start_send = 1'b1;
        check("idle_before_start", {31'd0, TDX}, 32'd1);
        @(posedge m_clock);
        #1;
        t0 = cyc;
        start_send = 1'b0;
        check("start_latency", {31'd0, TDX}, 32'd0);
        errs = 0;
        for (int i = 1; i < 10 * DIV; i++) begin
            @(posedge m_clock);
            #1;
            if (TDX !== frame0[i / DIV]) errs++;
        end
        check("frame0_levels", errs, 0);
        for (int b = 1; b < 7; b++) begin
            recv_byte(rx, ok, 4 * DIV);
            check($sformatf("msg_byte%0d", b), {23'd0, ok, rx}, {23'd0, 1'b1, msg[b]});
        end
        repeat (3 * DIV) @(negedge m_clock);
        check("msg_end_time", last_rise - t0, 69 * DIV);
        recv_byte(rx, ok, 3 * DIV);
        check("idle_after_msg", {31'd0, ok}, 32'd0);

        // Retrigger while busy is ignored
        pulse();
        good = 0;
        for (int b = 0; b < 2; b++) begin
            recv_byte(rx, ok, 4 * DIV);
            if (ok && rx === msg[b]) good++;
        end
        pulse();
        for (int b = 2; b < 7; b++) begin
            recv_byte(rx, ok, 4 * DIV);
            if (ok && rx === msg[b]) good++;
        end
        check("retrig_msg_bytes", good, 7);
        recv_byte(rx, ok, 12 * DIV);
        check("retrig_ignored", {31'd0, ok}, 32'd0);
        pulse();
        good = 0;
        for (int b = 0; b < 7; b++) begin
            recv_byte(rx, ok, 4 * DIV);
            if (ok && rx === msg[b]) good++;
        end
        check("second_msg_bytes", good, 7);
        recv_byte(rx, ok, 12 * DIV);
        check("second_msg_end", {31'd0, ok}, 32'd0);

        // Level hold sends exactly one message
        @(negedge m_clock);
        start_send = 1'b1;
        good = 0;
        for (int b = 0; b < 7; b++) begin
            recv_byte(rx, ok, 4 * DIV);
            if (ok && rx === msg[b]) good++;
        end
        check("hold_msg_bytes", good, 7);
        recv_byte(rx, ok, 800);
        check("hold_no_repeat", {31'd0, ok}, 32'd0);
        start_send = 1'b0;
        recv_byte(rx, ok, 3 * DIV);
        check("hold_release_idle", {31'd0, ok}, 32'd0);

        // Reset in the middle of byte 3
        pulse();
        good = 0;
        for (int b = 0; b < 3; b++) begin
            recv_byte(rx, ok, 4 * DIV);
            if (ok && rx === msg[b]) good++;
        end
        check("pre_reset_bytes", good, 3);
        repeat (DIV) @(negedge m_clock);
        check("byte3_start_low", {31'd0, TDX}, 32'd0);
        #2 p_reset = 1'b0;
        #1 check("async_reset_tdx", {31'd0, TDX}, 32'd1);
        repeat (3) @(negedge m_clock);
        check("reset_hold_idle", {31'd0, TDX}, 32'd1);
        p_reset = 1'b1;
        recv_byte(rx, ok, 12 * DIV);
        check("no_resume", {31'd0, ok}, 32'd0);
        pulse();
        recv_byte(rx, ok, 4 * DIV);
        check("restart_first_byte", {23'd0, ok, rx}, {23'd0, 1'b1, msg[0]});

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/serial_s.md
Name: serial_s

Overview:
- Fixed-message UART transmitter for the MAX10 board demo.
- A rising edge on start_send makes it send the ASCII string "Hello\r\n" (7 bytes: 0x48 0x65 0x6C 0x6C 0x6F 0x0D 0x0A) on TDX.
- Format is 8N1, LSB first, at a fixed baud rate derived from m_clock.
- Sits between a board push-button/strobe source and the board's UART TX pin.

Parameters:
- CLK_HZ, 50000000, m_clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- DIV, CLK_HZ/BAUD (integer division, 434), m_clock cycles per bit. Legal range is 2..65535.

Ports:
- m_clock  in  1  system clock; all state updates on its rising edge.
- p_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start_send  in  1  synchronous send request; edge-detected.
- TDX  out  1  UART transmit line; idle/mark = 1.

Behaviour:
- Reset (p_reset=0), applied asynchronously:
  - TDX=1, FSM=IDLE, baud counter=0, bit index=0, byte index=0, start_send history register=0.
- Trigger:
  - start_req = start_send & ~start_send_q, where start_send_q is start_send registered once.
  - start_req is honoured only in IDLE and is ignored while a message is in flight (not queued).
  - Holding start_send high sends exactly one message; it must return low, then high again, to re-trigger.
  - A 1-cycle pulse is sufficient.
- Latency: the start bit appears on TDX at the clock edge where start_req is registered, so TDX falls 1 cycle after start_send is first sampled high.
- FSM states and transitions:
  - IDLE: TDX=1. On start_req: byte index=0, load ROM[0] into the shift register, go to START.
  - START: TDX=0 for DIV cycles, then go to DATA with bit index=0.
  - DATA: TDX=shift[0] for DIV cycles per bit, then shift right. After bit 7, go to STOP.
  - STOP: TDX=1 for DIV cycles. Then, if byte index<6, increment the byte index, load the next ROM byte and go to START with no extra idle gap. Otherwise go to IDLE.
- Bit timing:
  - The baud counter runs 0..DIV-1 and wraps to 0 on the cycle the state or bit advances.
  - Every bit is exactly DIV clocks wide.
  - One frame is 10*DIV clocks (4340 = 86.8 us at the defaults).
  - The full message is 70*DIV clocks (30380 = 607.6 us).
- TDX is driven from a register; it is glitch-free with no combinational path from start_send.
- Message ROM: 7 entries, 8 bits wide, index width 3. Constant, synthesisable as LUT/case.
- Reset mid-frame: TDX returns to 1 immediately. The message is abandoned and is not resumed after reset release.
- start_req in the same cycle as the final STOP-bit completion: ignored, because the FSM is not in IDLE that cycle.

Optional Feature:
- Macro SERIAL_S_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits) for DIV cycles. Frame is 11*DIV clocks; message is 77*DIV clocks.
- Undefined: plain 8N1 as above; no parity logic is present.

Decomposition:
- Package serial_s_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - MSG_LEN=7.
  - The message byte constant array.
  - The default CLK_HZ and BAUD values.
- One natural sub-module, serial_s_tx_byte: baud counter plus START/DATA/[PARITY]/STOP serialiser.
  - Interface: load, data[7:0], busy, done-pulse, tx.
- The top level keeps the edge detector, message sequencer and ROM.

Test Plan:
- Reset hold: p_reset=0 for 5 cycles with start_send toggling -> TDX=1 throughout; no frame starts after release.
- Single pulse: 1-cycle start_send after reset -> TDX falls 1 cycle later, then follows the first frame.
  - First frame is 0,0,0,0,1,0,0,1,0,1 (start, 0x48 LSB-first, stop).
  - Each level lasts 434 cycles.
- Full message:
  - Decode TDX by sampling mid-bit -> bytes 0x48 0x65 0x6C 0x6C 0x6F 0x0D 0x0A.
  - TDX returns to 1 and stays idle after cycle 30380.
- Retrigger while busy: second start_send pulse 10000 cycles into the message -> ignored; exactly 7 bytes are sent. A pulse after IDLE sends 7 more.
- Level hold: start_send held high for 50000 cycles -> exactly one message is sent.
- Mid-frame reset: assert p_reset=0 during byte 3 -> TDX=1 asynchronously. After release, TDX stays idle until a new start_send edge, which restarts from 0x48.
